// File: rtl/ddr3_rd_engine.sv
// ddr3_rd_engine
// Streams a run of fixed-size read bursts from the DDR3 controller into the read FIFO.
// The engine runs entirely in the controller user clock domain.
// Requests are credit limited by the FIFO free space and by MAX_OUT in-flight reads.
// The final returned burst is tagged with fifo_tlast.
// Dropping start_req aborts a run: in-flight bursts are drained and discarded.
//
// Optional feature: define DDR3_RD_TIMEOUT_EN to enable a watchdog.
// The watchdog gives up on missing read data after TIMEOUT_CYCLES idle cycles.
//
// Ports
//   clk, reset          user clock, synchronous active-high reset
//   start_req           level request from another domain (rise = start, fall = abort/ack)
//   rd_start_addr       first burst address (held while start_req is high)
//   rd_burst_cnt        number of bursts in the run (held while start_req is high)
//   acq_enabled         acquisition writes active; read issue is held off
//   app_addr/app_en     read request to the controller, accepted when app_rdy is high
//   app_rdy             controller ready
//   app_rd_data_valid   one returned burst
//   fifo_free           free entries in the read FIFO
//   fifo_wr_en          write the returned burst into the FIFO
//   fifo_tlast          returned burst is the last of the run
//   busy                engine not idle
//   reading_done        run complete, held until start_req drops
//   err_unexpected      sticky: read data arrived with nothing outstanding
//   timeout             sticky: watchdog fired (always 0 without the feature)
module ddr3_rd_engine #(
    parameter int BADDR_W        = 23,
    parameter int ADDR_SHIFT     = 3,
    parameter int CNT_W          = 24,
    parameter int MAX_OUT        = 32,
    parameter int OUT_W          = 6,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_req,
    input  logic [BADDR_W-1:0]            rd_start_addr,
    input  logic [CNT_W-1:0]              rd_burst_cnt,
    input  logic                          acq_enabled,
    output logic [BADDR_W+ADDR_SHIFT-1:0] app_addr,
    output logic                          app_en,
    input  logic                          app_rdy,
    input  logic                          app_rd_data_valid,
    input  logic [OUT_W-1:0]              fifo_free,
    output logic                          fifo_wr_en,
    output logic                          fifo_tlast,
    output logic                          busy,
    output logic                          reading_done,
    output logic                          err_unexpected,
    output logic                          timeout
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    localparam logic [OUT_W-1:0] MAX_OUT_V = OUT_W'(MAX_OUT);

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sreq_d;
    logic                   r_start_pulse;
    logic [BADDR_W-1:0]     r_addr;
    logic [CNT_W-1:0]       r_issue_cnt;
    logic [CNT_W-1:0]       r_ret_cnt;
    logic [OUT_W-1:0]       r_out;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;
    logic                   r_timeout;

    logic w_sreq;
    logic w_start;
    logic w_app_en;
    logic w_accept;
    logic w_dec;
    logic w_counted;
    logic w_err_hit;
    logic w_to_fire;

    // start_req crosses in here; the edge detect runs on the synchronised level.
    assign w_sreq = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync        <= '0;
            r_sreq_d      <= 1'b0;
            r_start_pulse <= 1'b0;
        end else begin
            r_sync        <= {r_sync[SYNC_STAGES-2:0], start_req};
            r_sreq_d      <= w_sreq;
            r_start_pulse <= w_sreq && !r_sreq_d;
        end
    end

    // A start pulse outside IDLE is dropped: the requester must cycle start_req.
    assign w_start = r_start_pulse && (r_state == S_IDLE);

    assign w_app_en = (r_state == S_READ) && !acq_enabled && (r_issue_cnt != '0) &&
                      (r_out < fifo_free) && (r_out < MAX_OUT_V);
    assign w_accept = w_app_en && app_rdy;

    // Data is only credited against a real outstanding request; anything else is an error.
    assign w_err_hit = app_rd_data_valid && (r_out == '0);
    assign w_dec     = app_rd_data_valid && (r_out != '0) &&
                       ((r_state == S_READ) || (r_state == S_DRAIN));
    assign w_counted = app_rd_data_valid && (r_out != '0) && (r_state == S_READ);

`ifdef DDR3_RD_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wdog;
    logic            w_wd_run;

    assign w_wd_run  = ((r_state == S_READ) || (r_state == S_DRAIN)) && (r_out != '0);
    assign w_to_fire = w_wd_run && !app_rd_data_valid &&
                       (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdog <= '0;
        end else if (app_rd_data_valid || !w_wd_run || w_to_fire) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + WD_W'(1);
        end
    end
`else
    logic w_unused_timeout;

    assign w_to_fire        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    // Address, burst counters and the in-flight credit count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr      <= '0;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_out       <= '0;
        end else if (w_start) begin
            r_addr      <= rd_start_addr;
            r_issue_cnt <= rd_burst_cnt;
            r_ret_cnt   <= rd_burst_cnt;
            r_out       <= '0;
        end else begin
            if (w_accept) begin
                r_addr      <= r_addr + BADDR_W'(1);
                r_issue_cnt <= r_issue_cnt - CNT_W'(1);
            end
            if (w_counted) begin
                r_ret_cnt <= r_ret_cnt - CNT_W'(1);
            end
            // A watchdog expiry writes off every in-flight read.
            if (w_to_fire) begin
                r_out <= '0;
            end else if (w_accept && !w_dec) begin
                r_out <= r_out + OUT_W'(1);
            end else if (!w_accept && w_dec) begin
                r_out <= r_out - OUT_W'(1);
            end
        end
    end

    // Control FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_err_hit) begin
                r_err <= 1'b1;
            end
            if (w_to_fire) begin
                r_timeout <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (r_start_pulse) begin
                        r_err     <= w_err_hit;
                        r_timeout <= 1'b0;
                        r_busy    <= 1'b1;
                        if (rd_burst_cnt == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    // An abort wins over a run that completes in the same cycle.
                    if (!w_sreq) begin
                        r_state <= S_DRAIN;
                    end else if (w_to_fire || (w_counted && (r_ret_cnt == CNT_W'(1)))) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_to_fire || (r_out == '0)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (!w_sreq) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign app_addr       = {r_addr, {ADDR_SHIFT{1'b0}}};
    assign app_en         = w_app_en;
    assign fifo_wr_en     = w_counted;
    assign fifo_tlast     = w_counted && (r_ret_cnt == CNT_W'(1));
    assign busy           = r_busy;
    assign reading_done   = r_done;
    assign err_unexpected = r_err;
    assign timeout        = r_timeout;

endmodule

// File: tb/tb_ddr3_rd_engine.sv
// Bench for ddr3_rd_engine: table of complete read runs plus hand-written
// sequences for start latency, zero-length run, abort/drain, reset mid-run,
// acquisition hold-off and (with DDR3_RD_TIMEOUT_EN) the watchdog.
// A small controller model returns each accepted read a fixed number of cycles later.
module tb_ddr3_rd_engine;

`ifdef DDR3_RD_TIMEOUT_EN
    localparam int DLY_LONG = 12;
    localparam int DLY_MAX  = 14;
    localparam int EXP_MAX  = 14;
`else
    localparam int DLY_LONG = 20;
    localparam int DLY_MAX  = 40;
    localparam int EXP_MAX  = 32;
`endif

    logic        clk;
    logic        reset;
    logic        start_req;
    logic [22:0] rd_start_addr;
    logic [23:0] rd_burst_cnt;
    logic        acq_enabled;
    logic [25:0] app_addr;
    logic        app_en;
    logic        app_rdy;
    logic        app_rd_data_valid = 1'b0;
    logic [5:0]  fifo_free;
    logic        fifo_wr_en;
    logic        fifo_tlast;
    logic        busy;
    logic        reading_done;
    logic        err_unexpected;
    logic        timeout;

    ddr3_rd_engine #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .start_req(start_req),
        .rd_start_addr(rd_start_addr), .rd_burst_cnt(rd_burst_cnt),
        .acq_enabled(acq_enabled), .app_addr(app_addr), .app_en(app_en),
        .app_rdy(app_rdy), .app_rd_data_valid(app_rd_data_valid),
        .fifo_free(fifo_free), .fifo_wr_en(fifo_wr_en), .fifo_tlast(fifo_tlast),
        .busy(busy), .reading_done(reading_done),
        .err_unexpected(err_unexpected), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Controller model: drives valid at the negedge, samples requests/writes 1 ns later.
    int          cyc_n = 0;
    int          due_q[$];
    logic [25:0] acc_q[$];
    int          acc_total = 0, ret_total = 0, wr_total = 0, tlast_total = 0;
    int          tlast_at = 0, en_cycles = 0, extra_done = 0, last_valid_cyc = 0;
    int          delay_cfg = 5;
    int          mem_limit = 1 << 30;
    int          extra_req = 0;

    always @(negedge clk) begin
        cyc_n = cyc_n + 1;
        if (extra_req > extra_done) begin
            app_rd_data_valid = 1'b1;
            extra_done        = extra_done + 1;
            last_valid_cyc    = cyc_n;
        end else if (due_q.size() > 0 && due_q[0] <= cyc_n && ret_total < mem_limit) begin
            void'(due_q.pop_front());
            app_rd_data_valid = 1'b1;
            ret_total         = ret_total + 1;
            last_valid_cyc    = cyc_n;
        end else begin
            app_rd_data_valid = 1'b0;
        end
        #1;
        if (app_en) en_cycles = en_cycles + 1;
        if (app_en && app_rdy) begin
            acc_q.push_back(app_addr);
            due_q.push_back(cyc_n + delay_cfg);
            acc_total = acc_total + 1;
        end
        if (fifo_wr_en) begin
            wr_total = wr_total + 1;
            if (fifo_tlast) begin
                tlast_total = tlast_total + 1;
                tlast_at    = wr_total;
            end
        end
    end

    typedef struct {
        logic [22:0] addr;
        logic [23:0] cnt;
        logic [5:0]  free;
        int          dly;
        logic [25:0] first;
        int          writes;
        int          max_out;
    } vec_t;

    vec_t vecs[4];

    task automatic run_vec(input vec_t v, input string tag);
        int acc_b, ret_b, wr_b, tl_b, mx, cur, n, addr_bad;
        logic [25:0] exp_a;
        @(negedge clk);
        delay_cfg     = v.dly;
        rd_start_addr = v.addr;
        rd_burst_cnt  = v.cnt;
        fifo_free     = v.free;
        app_rdy       = 1'b1;
        acq_enabled   = 1'b0;
        acc_b = acc_total; ret_b = ret_total; wr_b = wr_total; tl_b = tlast_total;
        mx = 0; n = 0;
        start_req = 1'b1;
        do begin
            @(negedge clk); #2;
            n++;
            cur = (acc_total - acc_b) - (ret_total - ret_b);
            if (cur > mx) mx = cur;
        end while (!reading_done && n < 3000);
        check({tag, "_done"}, reading_done, 1);
        check({tag, "_accepts"}, acc_total - acc_b, v.writes);
        check({tag, "_writes"}, wr_total - wr_b, v.writes);
        check({tag, "_tlast_cnt"}, tlast_total - tl_b, 1);
        check({tag, "_tlast_pos"}, tlast_at - wr_b, v.writes);
        check({tag, "_max_out"}, mx, v.max_out);
        check({tag, "_err"}, err_unexpected, 0);
        addr_bad = 0;
        for (int i = 0; i < acc_total - acc_b; i++) begin
            exp_a = v.first + 26'(8 * i);
            if (acc_q[acc_b + i] !== exp_a) addr_bad++;
        end
        check({tag, "_addr_seq_errs"}, addr_bad, 0);
        @(negedge clk);
        start_req = 1'b0;
        n = 0;
        do begin @(negedge clk); #2; n++; end while (busy && n < 20);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_done"}, reading_done, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got running, want finished");
        $fatal(1, "time limit");
    end

    initial begin
        int n, acc_b, ret_b, wr_b, tl_b, en_b, b3, b4, d4;
`ifdef DDR3_RD_TIMEOUT_EN
        int to_cyc;
`endif
        vecs[0] = '{23'h000010, 24'd4,   6'd8,  5,        26'h0000080, 4,   4};
        vecs[1] = '{23'h000000, 24'd100, 6'd3,  DLY_LONG, 26'h0000000, 100, 3};
        vecs[2] = '{23'h7FFFFE, 24'd4,   6'd8,  5,        26'h3FFFFF0, 4,   4};
        vecs[3] = '{23'h000100, 24'd40,  6'd63, DLY_MAX,  26'h0000800, 40,  EXP_MAX};

        reset = 1'b1; start_req = 1'b0; rd_start_addr = '0; rd_burst_cnt = '0;
        acq_enabled = 1'b0; app_rdy = 1'b0; fifo_free = '0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_app_en", app_en, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_tlast", fifo_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_done", reading_done, 0);
        check("rst_err", err_unexpected, 0);
        check("rst_timeout", timeout, 0);
        check("rst_app_addr", app_addr, 0);
        @(negedge clk);
        reset = 1'b0;

        // Zero-length run: start latency and direct entry to DONE.
        @(negedge clk);
        rd_burst_cnt = 24'd0; rd_start_addr = 23'h000123; fifo_free = 6'd8; app_rdy = 1'b1;
        acc_b = acc_total; wr_b = wr_total; en_b = en_cycles;
        start_req = 1'b1;
        b3 = 0; b4 = 0; d4 = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); #2;
            if (k == 3) b3 = busy;
            if (k == 4) begin b4 = busy; d4 = reading_done; end
        end
        check("cnt0_busy_before_pulse", b3, 0);
        check("cnt0_busy_after_pulse", b4, 1);
        check("cnt0_done", d4, 1);
        repeat (5) @(negedge clk);
        #2;
        check("cnt0_app_en_cycles", en_cycles - en_b, 0);
        check("cnt0_writes", wr_total - wr_b, 0);
        @(negedge clk);
        start_req = 1'b0;
        n = 0;
        do begin @(negedge clk); #2; n++; end while (busy && n < 20);
        check("cnt0_idle", busy, 0);

        // Abort after 10 accepts with 6 reads in flight.
        @(negedge clk);
        delay_cfg = 6; rd_start_addr = 23'h000200; rd_burst_cnt = 24'd64;
        fifo_free = 6'd63; app_rdy = 1'b1;
        acc_b = acc_total; ret_b = ret_total; wr_b = wr_total; tl_b = tlast_total;
        mem_limit = ret_total + 4;
        start_req = 1'b1;
        n = 0;
        do begin @(negedge clk); #2; n++; end while ((acc_total - acc_b) < 10 && n < 100);
        @(negedge clk);
        app_rdy = 1'b0; start_req = 1'b0;
        repeat (4) begin @(negedge clk); #2; end
        check("abort_accepts", acc_total - acc_b, 10);
        check("abort_returned_before_drain", ret_total - ret_b, 4);
        check("abort_drain_app_en", app_en, 0);
        check("abort_drain_busy", busy, 1);
        mem_limit = 1 << 30;
        n = 0;
        do begin @(negedge clk); #2; n++; end while (busy && n < 60);
        check("abort_idle", busy, 0);
        check("abort_returned_total", ret_total - ret_b, 10);
        check("abort_writes", wr_total - wr_b, 4);
        check("abort_tlast", tlast_total - tl_b, 0);
        check("abort_err_before_extra", err_unexpected, 0);
        extra_req++;
        repeat (3) begin @(negedge clk); #2; end
        check("abort_err_after_extra", err_unexpected, 1);
        check("abort_writes_after_extra", wr_total - wr_b, 4);

        // Complete runs; the first also shows a new start clearing err_unexpected.
        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a run; the late data must flag an error.
        @(negedge clk);
        delay_cfg = 10; rd_start_addr = 23'h0; rd_burst_cnt = 24'd20;
        fifo_free = 6'd63; app_rdy = 1'b1;
        acc_b = acc_total;
        start_req = 1'b1;
        n = 0;
        do begin @(negedge clk); #2; n++; end while ((acc_total - acc_b) < 5 && n < 50);
        @(negedge clk);
        reset = 1'b1; start_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #2;
        wr_b = wr_total;
        check("rstmid_busy", busy, 0);
        check("rstmid_app_en", app_en, 0);
        check("rstmid_err_clear", err_unexpected, 0);
        n = 0;
        do begin @(negedge clk); #2; n++; end while (due_q.size() > 0 && n < 60);
        repeat (2) begin @(negedge clk); #2; end
        check("rstmid_late_err", err_unexpected, 1);
        check("rstmid_late_writes", wr_total - wr_b, 0);

        // Acquisition active holds off all requests.
        @(negedge clk);
        delay_cfg = 3; rd_start_addr = 23'h000040; rd_burst_cnt = 24'd2;
        fifo_free = 6'd8; app_rdy = 1'b1; acq_enabled = 1'b1;
        acc_b = acc_total; wr_b = wr_total; en_b = en_cycles;
        start_req = 1'b1;
        repeat (20) begin @(negedge clk); #2; end
        check("acq_app_en_cycles", en_cycles - en_b, 0);
        check("acq_busy", busy, 1);
        check("acq_err_cleared", err_unexpected, 0);
        @(negedge clk);
        acq_enabled = 1'b0;
        n = 0;
        do begin @(negedge clk); #2; n++; end while (!reading_done && n < 50);
        check("acq_done", reading_done, 1);
        check("acq_writes", wr_total - wr_b, 2);
        @(negedge clk);
        start_req = 1'b0;
        n = 0;
        do begin @(negedge clk); #2; n++; end while (busy && n < 20);
        check("acq_idle", busy, 0);
        check("acq_no_timeout", timeout, 0);

`ifdef DDR3_RD_TIMEOUT_EN
        // Two bursts requested, only one returned: the watchdog ends the run.
        @(negedge clk);
        delay_cfg = 3; rd_start_addr = 23'h000010; rd_burst_cnt = 24'd2;
        fifo_free = 6'd8; app_rdy = 1'b1;
        wr_b = wr_total; tl_b = tlast_total;
        mem_limit = ret_total + 1;
        start_req = 1'b1;
        n = 0;
        do begin @(negedge clk); #2; n++; end while (!timeout && n < 100);
        to_cyc = cyc_n;
        check("to_flag", timeout, 1);
        // Valid taken at the edge ending cycle v, flag set 16 edges later,
        // first visible in cycle v+17.
        check("to_delay", to_cyc - last_valid_cyc, 17);
        check("to_done", reading_done, 1);
        check("to_app_en", app_en, 0);
        check("to_writes", wr_total - wr_b, 1);
        check("to_tlast", tlast_total - tl_b, 0);
        extra_req++;
        repeat (3) begin @(negedge clk); #2; end
        check("to_outstanding_zero", err_unexpected, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
